// File: rtl/seq_fxp_multiplier.sv
// Shift-add signed fixed-point multiplier, one multiplier bit per clock.
// Ports: clk, reset(n), start -> busy, done pulse, P (Q.FRAC), ovf.
module seq_fxp_multiplier #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] P,
  output logic             ovf
);

  localparam int AW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [AW-1:0] POS_MAX =
    {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [AW-1:0] NEG_MAX =
    {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] P_POS =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] P_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    FIN
  } state_t;

  state_t           state, state_n;
  logic [AW-1:0]    acc, acc_n;
  logic [WIDTH-1:0] mag_a, mag_a_n;
  logic [WIDTH-1:0] mag_b, mag_b_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             sign, sign_n;
  logic             busy_n, done_n, ovf_n;
  logic [WIDTH-1:0] p_n;
  logic [AW-1:0]    mag;

  // |x| as unsigned; the most negative value maps onto itself,
  // which is exactly 2^(WIDTH-1) when read unsigned.
  function automatic logic [WIDTH-1:0] absv(
    input logic [WIDTH-1:0] x
  );
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  assign mag = acc >> FRAC;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      acc   <= '0;
      mag_a <= '0;
      mag_b <= '0;
      cnt   <= '0;
      sign  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      P     <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      mag_a <= mag_a_n;
      mag_b <= mag_b_n;
      cnt   <= cnt_n;
      sign  <= sign_n;
      busy  <= busy_n;
      done  <= done_n;
      P     <= p_n;
      ovf   <= ovf_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    mag_a_n = mag_a;
    mag_b_n = mag_b;
    cnt_n   = cnt;
    sign_n  = sign;
    busy_n  = busy;
    done_n  = 1'b0;
    p_n     = P;
    ovf_n   = ovf;
    unique case (state)
      IDLE: begin
        if (start) begin
          sign_n  = A[WIDTH-1] ^ B[WIDTH-1];
          mag_a_n = absv(A);
          mag_b_n = absv(B);
          acc_n   = '0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = MUL;
        end
      end
      MUL: begin
        if (mag_b[cnt])
          acc_n = acc + ({{WIDTH{1'b0}}, mag_a} << cnt);
        cnt_n = cnt + 1'b1;
        if (cnt == LAST)
          state_n = FIN;
      end
      FIN: begin
        if (!sign && mag > POS_MAX) begin
          p_n   = P_POS;
          ovf_n = 1'b1;
        end else if (sign && mag > NEG_MAX) begin
          p_n   = P_NEG;
          ovf_n = 1'b1;
        end else begin
          p_n   = sign ? (~mag[WIDTH-1:0] + 1'b1)
                       : mag[WIDTH-1:0];
          ovf_n = 1'b0;
        end
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_fxp_multiplier.sv
// Self-checking bench for seq_fxp_multiplier: directed corners,
// reset abort, back-to-back starts and random operands vs a model.
module tb_seq_fxp_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] A, B;
  logic        busy, done, ovf;
  logic [15:0] P;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_fxp_multiplier #(.WIDTH(16), .FRAC(8)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .P    (P),
    .ovf  (ovf)
  );

  // Reference: exact signed product, magnitude truncated, then
  // saturated to the Q8.8 range. Returns {ovf, P}.
  function automatic logic [16:0] model(
    input logic [15:0] a,
    input logic [15:0] b
  );
    longint pr, m;
    logic   s;
    pr = longint'($signed(a)) * longint'($signed(b));
    m  = (pr < 0) ? -pr : pr;
    m  = m / 256;
    s  = a[15] ^ b[15];
    if (!s && m > 32767) return {1'b1, 16'h7FFF};
    if (s && m > 32768)  return {1'b1, 16'h8000};
    if (s) return {1'b0, 16'(-m)};
    return {1'b0, 16'(m)};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(
    input string       tag,
    input logic [15:0] a,
    input logic [15:0] b,
    input bit          full
  );
    logic [16:0] e;
    int n;
    e = model(a, b);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    A = 16'($urandom); B = 16'($urandom);
    if (full) chk({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1 n++;
      if (full && !done) chk({tag, "_busyh"}, 32'(busy), 32'd1);
    end
    if (full) chk({tag, "_lat"}, n, 17);
    else if (n >= 40) chk({tag, "_timeout"}, n, 17);
    chk({tag, "_P"}, 32'(P), 32'(e[15:0]));
    chk({tag, "_ovf"}, 32'(ovf), 32'(e[16]));
    if (full) begin
      chk({tag, "_bdone"}, 32'(busy), 32'd0);
      @(posedge clk);
      #1 chk({tag, "_pulse"}, 32'(done), 32'd0);
      chk({tag, "_hold"}, 32'(P), 32'(e[15:0]));
    end
  endtask

  logic [31:0] q[$];
  logic [31:0] ent;
  logic [16:0] ex;
  int          spur;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_P", 32'(P), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk) reset = 1'b1;

    run_op("m15x2", 16'h0180, 16'h0200, 1);
    run_op("mn15x2", 16'hFE80, 16'h0200, 1);
    run_op("mnn", 16'hFE80, 16'hFE00, 1);
    run_op("tiny", 16'h0001, 16'h0001, 1);
    run_op("negtiny", 16'hFFFF, 16'h0001, 1);
    run_op("zero", 16'h0000, 16'h8000, 1);
    run_op("satp", 16'h7FFF, 16'h7FFF, 1);
    run_op("minx1", 16'h8000, 16'h0100, 1);
    run_op("minmin", 16'h8000, 16'h8000, 1);
    run_op("pre_rst", 16'h0300, 16'h0300, 1);

    // abort mid-operation
    @(negedge clk);
    A = 16'h0180; B = 16'h0200; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_P", 32'(P), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    @(negedge clk) reset = 1'b1;
    spur = 0;
    repeat (25) begin
      @(posedge clk);
      #1 if (done) spur++;
    end
    chk("no_spur_done", spur, 0);
    run_op("post_rst", 16'h0180, 16'h0200, 1);

    // start held high, operands change every cycle
    for (int k = 0; k < 72; k++) begin
      @(negedge clk);
      A = 16'($urandom_range(0, 16'hFFFF) >> $urandom_range(0, 7));
      B = 16'($urandom_range(0, 16'hFFFF) >> $urandom_range(0, 7));
      start = 1'b1;
      @(posedge clk);
      if (k % 18 == 0) q.push_back({A, B});
      #1;
      chk("b2b_done", 32'(done), 32'(k % 18 == 17));
      if (k % 18 == 17) begin
        ent = q.pop_front();
        ex  = model(ent[31:16], ent[15:0]);
        chk("b2b_P", 32'(P), 32'(ex[15:0]));
        chk("b2b_ovf", 32'(ovf), 32'(ex[16]));
      end
    end
    @(negedge clk) start = 1'b0;
    @(posedge clk);

    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      // shrink some operands so in-range results are common
      if (i % 3 != 0) ra = 16'($signed(ra) >>> $urandom_range(0, 8));
      if (i % 2 != 0) rb = 16'($signed(rb) >>> $urandom_range(0, 8));
      run_op("rand", ra, rb, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
